uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver that consumes the `tx` line of the existing UART transmitter. It recovers 8-bit bytes from frames of 1 start bit (0), 8 data bits sent LSB first, and 1 stop bit (1).
- Each recovered byte is presented on a valid/ready output port with a one-entry holding register.
- Framing errors and overruns are reported as single-cycle pulses.
- Default bit time is one clock per bit, matching the transmitter.

Parameters:
- CLKS_PER_BIT, 1, clocks per serial bit; legal range 1..255.
- HALF_BIT, CLKS_PER_BIT/2 (integer division), sample offset from the falling edge of the start bit.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  serial line; idle high.
- data_out  output  8  received byte; stable while valid=1.
- valid  output  1  data_out holds an unconsumed byte.
- ready  input  1  consumer accepts the byte on a clk edge where valid&&ready.
- busy  output  1  a frame is in progress (state != IDLE).
- framing_err  output  1  one-cycle pulse: stop bit sampled as 0.
- overrun  output  1  one-cycle pulse: good byte dropped because the holding register was full.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, bit counter=0, clock counter=0, valid=0, data_out=8'h00, framing_err=0, overrun=0, busy=0, shift register=0. Deassertion of rst_n is synchronous to clk.
- Reset mid-frame aborts the frame with no pulses. After release the block waits in IDLE for rx=0.
- `rxs` is the rx value used by the state machine: raw rx, or the synchronised rx when the optional feature is compiled in.
- States:
  - IDLE: if rxs=0, go to START and clear the clock counter. When CLKS_PER_BIT=1, go directly to DATA instead; the start is confirmed by that sample.
  - START: count to HALF_BIT. If rxs=1 at that sample, treat as a glitch and return to IDLE silently. Otherwise go to DATA with clock counter=0.
  - DATA: sample every CLKS_PER_BIT clocks. Shift rxs into bit[bitcnt]. After the 8th sample (bitcnt=7) go to STOP.
  - STOP: sample after CLKS_PER_BIT clocks.
    - rxs=1: byte complete; go to IDLE.
    - rxs=0: pulse framing_err, discard the byte, go to BREAK.
  - BREAK: wait for rxs=1, then go to IDLE. Prevents re-triggering on a held-low line.
- Timing at CLKS_PER_BIT=1, feature off:
  - Edge E0 samples the start bit; edges E1..E8 sample data[0..7]; E9 samples the stop bit.
  - valid rises on E9, so it is visible in the cycle after E9.
  - IDLE is re-entered at E9; a new start bit can be sampled at E10. Back-to-back frames with a 1-cycle stop bit are received without loss.
- Output handshake:
  - valid is set on byte completion.
  - valid clears on an edge with valid&&ready unless a new byte completes on that same edge. In that case data_out is loaded with the new byte, valid stays 1, and no overrun is raised.
  - Byte completes while valid=1 and ready=0: the old byte is kept, the new byte is dropped, and overrun pulses for 1 cycle.
  - data_out changes only when a byte is loaded.
- Counters: bit counter is 3 bits and wraps only via state change. Clock counter is 8 bits and resets on every sample.
- framing_err and overrun are registered, cleared every cycle unless re-asserted, and never both set in the same cycle.

Optional Feature:
- UART_RX_SYNC_EN:
  - Defined: rx passes through a 2-flop synchroniser; both flops reset to 1. All state-machine latencies grow by 2 cycles (valid appears on E11 relative to rx's start-bit edge E0). The glitch check and handshake are unchanged.
  - Undefined: rx is used directly. Legal only when rx is driven synchronously from clk, as it is by the UART transmitter.

Test Plan:
- CLKS_PER_BIT=1, ready=1. Transmitter sends 0xA5 then 0x3C back-to-back. Required: valid pulses 1 cycle with data_out=0xA5, then 0x3C 10 cycles later; no error pulses.
- rx driven 0, 8'h55 bits, then stop=0, then held 0 for 5 cycles, then 1. Required: framing_err pulses exactly once; valid stays 0; next frame 0x81 is received correctly.
- ready=0. Send 0x11 then 0x22. Required: data_out=0x11, valid=1, overrun pulses once when 0x22 completes. Then ready=1 for 1 cycle: valid drops and data_out stays 0x11.
- valid=1 with 0x11; ready asserted exactly on the edge that completes 0x99. Required: data_out=0x99, valid=1, no overrun.
- CLKS_PER_BIT=16. rx low pulse of 4 clocks. Required: return to IDLE, busy low again, no valid or framing_err. A full 0xC3 frame at 16 clks/bit yields data_out=0xC3.
- rst_n asserted after 4 data bits of 0xFF, released, then 0x5A sent. Required: outputs 0 during reset, no pulses; 0x5A received intact. Repeat with UART_RX_SYNC_EN defined: valid appears 2 cycles later.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data bits LSB first, 1 stop, one-entry valid/ready holding register.
// Define UART_RX_SYNC_EN to pass rx through a 2-flop synchroniser (adds 2 cycles of latency).
module uart_rx #(
    parameter int CLKS_PER_BIT = 1,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    input  logic       ready,
    output logic       busy,
    output logic       framing_err,
    output logic       overrun,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    localparam logic [7:0] BIT_LAST  = 8'(CLKS_PER_BIT - 1);
    localparam logic [7:0] HALF_LAST = 8'((HALF_BIT > 0) ? HALF_BIT - 1 : 0);

    state_t     state_q, state_d;
    logic [7:0] clk_cnt;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       rxs;
    logic       tick, byte_done, frame_bad;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync_q <= 2'b11;
        else        sync_q <= {sync_q[0], rx};
    end
    assign rxs = sync_q[1];
`else
    assign rxs = rx;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        tick      = 1'b0;
        byte_done = 1'b0;
        frame_bad = 1'b0;
        unique case (state_q)
            IDLE: begin
                // At one clock per bit the start bit is confirmed by the very sample that sees it.
                if (!rxs) begin
                    if (CLKS_PER_BIT == 1) state_d = DATA;
                    else                   state_d = START;
                end
            end
            START: begin
                if (clk_cnt == HALF_LAST) begin
                    tick = 1'b1;
                    if (rxs) state_d = IDLE;
                    else     state_d = DATA;
                end
            end
            DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    tick = 1'b1;
                    if (bit_cnt == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (clk_cnt == BIT_LAST) begin
                    tick = 1'b1;
                    if (rxs) begin
                        byte_done = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = BRK;
                    end
                end
            end
            BRK: begin
                if (rxs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state_q != IDLE);
        state_dbg = state_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_cnt <= 8'd0;
            bit_cnt <= 3'd0;
            shreg   <= 8'd0;
        end else begin
            if (state_q == IDLE || state_q == BRK) begin
                clk_cnt <= 8'd0;
                bit_cnt <= 3'd0;
            end else if (tick) begin
                clk_cnt <= 8'd0;
            end else begin
                clk_cnt <= clk_cnt + 8'd1;
            end
            if (state_q == DATA && tick) begin
                shreg[bit_cnt] <= rxs;
                bit_cnt        <= bit_cnt + 3'd1;
            end
        end
    end

    // Handshake: a byte transfers on any edge with valid && ready; valid never drops without
    // that transfer, and data_out only changes when a completed byte is loaded. A byte that
    // completes on the transfer edge replaces the outgoing one; otherwise a full register drops it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out    <= 8'h00;
            valid       <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            framing_err <= frame_bad;
            overrun     <= byte_done && valid && !ready;
            if (byte_done && (!valid || ready)) begin
                data_out <= shreg;
                valid    <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one instance at 1 clk/bit, one at 16 clks/bit.
// Latency expectations shift by 2 cycles when built with UART_RX_SYNC_EN.
module tb_uart_rx;

`ifdef UART_RX_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx1, rdy1, rx16, rdy16;
    logic [7:0] data1, data16;
    logic       valid1, busy1, ferr1, ovr1;
    logic       valid16, busy16, ferr16, ovr16;
    logic [2:0] st1, st16;

    uart_rx #(.CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .rx(rx1), .data_out(data1), .valid(valid1),
        .ready(rdy1), .busy(busy1), .framing_err(ferr1), .overrun(ovr1), .state_dbg(st1)
    );

    uart_rx #(.CLKS_PER_BIT(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .rx(rx16), .data_out(data16), .valid(valid16),
        .ready(rdy16), .busy(busy16), .framing_err(ferr16), .overrun(ovr16), .state_dbg(st16)
    );

    // clock / cycle index
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [7:0] exp_q[$];
    int         acc_cyc_q[$];
    int         n_cmp = 0;
    int         n_err = 0;
    int         vhigh1 = 0, nf1 = 0, no1 = 0, nf16 = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // monitor: counts pulses and scores every byte transfer on dut1
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid1) vhigh1++;
            if (ferr1)  nf1++;
            if (ovr1)   no1++;
            if (ferr16) nf16++;
            if (valid1 && rdy1) begin
                int depth;
                acc_cyc_q.push_back(cyc);
                depth = exp_q.size();
                chk("acc_expected_present", 32'(depth != 0), 32'd1);
                if (depth != 0) chk("acc_data", 32'(data1), 32'(exp_q.pop_front()));
            end
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle1(input int n);
        rx1 = 1'b1;
        repeat (n) step();
    endtask

    task automatic send1(input logic [7:0] b, input logic stopb, output int e0);
        e0  = cyc + 1;
        rx1 = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            rx1 = b[i];
            step();
        end
        rx1 = stopb;
        step();
    endtask

    task automatic send16(input logic [7:0] b);
        rx16 = 1'b0;
        repeat (16) step();
        for (int i = 0; i < 8; i++) begin
            rx16 = b[i];
            repeat (16) step();
        end
        rx16 = 1'b1;
        repeat (16) step();
    endtask

    int e0a, e0b, a0, v0, f0, o0, f16;

    initial begin
        // reset
        rst_n = 1'b0; rx1 = 1'b1; rx16 = 1'b1; rdy1 = 1'b0; rdy16 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid1", 32'(valid1), 32'd0);
        chk("rst_data1", 32'(data1), 32'h00);
        chk("rst_busy1", 32'(busy1), 32'd0);
        chk("rst_ferr1", 32'(ferr1), 32'd0);
        chk("rst_ovr1", 32'(ovr1), 32'd0);
        chk("rst_state1", 32'(st1), 32'd0);
        chk("rst_valid16", 32'(valid16), 32'd0);
        chk("rst_busy16", 32'(busy16), 32'd0);
        rst_n = 1'b1;
        idle1(3);

        // back-to-back 0xA5, 0x3C with ready held high
        rdy1 = 1'b1;
        a0 = acc_cyc_q.size(); v0 = vhigh1; f0 = nf1; o0 = no1;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h3C);
        send1(8'hA5, 1'b1, e0a);
        send1(8'h3C, 1'b1, e0b);
        idle1(6);
        chk("b2b_count", 32'(acc_cyc_q.size() - a0), 32'd2);
        if (acc_cyc_q.size() - a0 == 2) begin
            chk("b2b_first_latency", 32'(acc_cyc_q[a0]), 32'(e0a + 9 + LAT));
            chk("b2b_spacing", 32'(acc_cyc_q[a0+1] - acc_cyc_q[a0]), 32'd10);
        end
        chk("b2b_valid_cycles", 32'(vhigh1 - v0), 32'd2);
        chk("b2b_no_ferr", 32'(nf1 - f0), 32'd0);
        chk("b2b_no_ovr", 32'(no1 - o0), 32'd0);

        // framing error on 0x55 with held-low line, then 0x81
        a0 = acc_cyc_q.size(); v0 = vhigh1; f0 = nf1;
        send1(8'h55, 1'b0, e0a);
        rx1 = 1'b0;
        repeat (5) step();
        chk("brk_busy", 32'(busy1), 32'd1);
        chk("brk_state", 32'(st1), 32'd4);
        idle1(4);
        chk("brk_exit_busy", 32'(busy1), 32'd0);
        chk("ferr_once", 32'(nf1 - f0), 32'd1);
        chk("ferr_no_valid", 32'(vhigh1 - v0), 32'd0);
        exp_q.push_back(8'h81);
        send1(8'h81, 1'b1, e0a);
        idle1(6);
        chk("after_ferr_count", 32'(acc_cyc_q.size() - a0), 32'd1);
        chk("after_ferr_no_new_ferr", 32'(nf1 - f0), 32'd1);

        // overrun: 0x11 held, 0x22 dropped
        rdy1 = 1'b0;
        a0 = acc_cyc_q.size(); o0 = no1;
        send1(8'h11, 1'b1, e0a);
        send1(8'h22, 1'b1, e0b);
        idle1(6);
        chk("ovr_valid", 32'(valid1), 32'd1);
        chk("ovr_data_kept", 32'(data1), 32'h11);
        chk("ovr_once", 32'(no1 - o0), 32'd1);
        exp_q.push_back(8'h11);
        rdy1 = 1'b1;
        step();
        rdy1 = 1'b0;
        chk("ovr_consume_valid", 32'(valid1), 32'd0);
        chk("ovr_consume_data", 32'(data1), 32'h11);
        step();
        chk("ovr_consume_count", 32'(acc_cyc_q.size() - a0), 32'd1);

        // ready on the same edge a new byte completes
        send1(8'h11, 1'b1, e0a);
        idle1(4);
        chk("coll_pre_valid", 32'(valid1), 32'd1);
        chk("coll_pre_data", 32'(data1), 32'h11);
        a0 = acc_cyc_q.size(); o0 = no1;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h99);
        rx1 = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            rx1 = (8'h99 >> i) & 8'h01;
            step();
        end
        rx1 = 1'b1;
        repeat (LAT) step();
        rdy1 = 1'b1;
        step();
        rdy1 = 1'b0;
        chk("coll_data", 32'(data1), 32'h99);
        chk("coll_valid", 32'(valid1), 32'd1);
        chk("coll_no_ovr_pulse", 32'(ovr1), 32'd0);
        step();
        rdy1 = 1'b1;
        step();
        rdy1 = 1'b0;
        idle1(2);
        chk("coll_count", 32'(acc_cyc_q.size() - a0), 32'd2);
        chk("coll_no_ovr", 32'(no1 - o0), 32'd0);
        chk("coll_drained", 32'(valid1), 32'd0);

        // 16 clks/bit: short glitch then 0xC3
        f16 = nf16;
        rx16 = 1'b0;
        repeat (4) step();
        rx16 = 1'b1;
        step();
        chk("glitch_busy", 32'(busy16), 32'd1);
        repeat (10) step();
        chk("glitch_idle", 32'(busy16), 32'd0);
        chk("glitch_no_valid", 32'(valid16), 32'd0);
        chk("glitch_no_ferr", 32'(nf16 - f16), 32'd0);
        send16(8'hC3);
        chk("c16_valid", 32'(valid16), 32'd1);
        chk("c16_data", 32'(data16), 32'hC3);
        chk("c16_no_ferr", 32'(nf16 - f16), 32'd0);
        rdy16 = 1'b1;
        step();
        rdy16 = 1'b0;
        chk("c16_consumed", 32'(valid16), 32'd0);

        // reset in the middle of a 0xFF frame, then 0x5A
        rdy1 = 1'b1;
        a0 = acc_cyc_q.size(); f0 = nf1; o0 = no1;
        rx1 = 1'b0;
        step();
        for (int i = 0; i < 4; i++) begin
            rx1 = 1'b1;
            step();
        end
        chk("midframe_busy", 32'(busy1), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(valid1), 32'd0);
        chk("mrst_data", 32'(data1), 32'h00);
        chk("mrst_busy", 32'(busy1), 32'd0);
        chk("mrst_ferr", 32'(ferr1), 32'd0);
        chk("mrst_ovr", 32'(ovr1), 32'd0);
        repeat (3) step();
        chk("mrst_hold_busy", 32'(busy1), 32'd0);
        rst_n = 1'b1;
        idle1(2);
        chk("mrst_release_busy", 32'(busy1), 32'd0);
        exp_q.push_back(8'h5A);
        send1(8'h5A, 1'b1, e0a);
        idle1(6);
        chk("mrst_count", 32'(acc_cyc_q.size() - a0), 32'd1);
        if (acc_cyc_q.size() - a0 == 1)
            chk("mrst_latency", 32'(acc_cyc_q[a0]), 32'(e0a + 9 + LAT));
        chk("mrst_no_ferr", 32'(nf1 - f0), 32'd0);
        chk("mrst_no_ovr", 32'(no1 - o0), 32'd0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        // report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
